// File: rtl/gmii_gtp_gearbox_if.sv
// GMII/GTP gearbox bus bundle.
// slave side is the gearbox, master side feeds it.
interface gmii_gtp_gearbox_if #(
  parameter int DW = 10
);
  logic [DW-1:0]   gmii_txd;
  logic [2*DW-1:0] gtp_txd;
  logic            gtp_tx_stb;
  logic [2*DW-1:0] gtp_rxd;
  logic            gtp_rx_stb;
  logic [DW-1:0]   gmii_rxd;
  logic            gmii_rx_valid;
  logic            rx_overrun;
  logic [7:0]      rx_overrun_cnt;

  modport master (
    output gmii_txd, gtp_rxd, gtp_rx_stb,
    input  gtp_txd, gtp_tx_stb,
    input  gmii_rxd, gmii_rx_valid,
    input  rx_overrun, rx_overrun_cnt
  );

  modport slave (
    input  gmii_txd, gtp_rxd, gtp_rx_stb,
    output gtp_txd, gtp_tx_stb,
    output gmii_rxd, gmii_rx_valid,
    output rx_overrun, rx_overrun_cnt
  );
endinterface

// File: rtl/gmii_gtp_gearbox.sv
// 1:2 / 2:1 gearbox between GMII symbols and GTP words.
// GMII_GTP_LOOPBACK_EN adds an internal TX->RX loopback select.
module gmii_gtp_gearbox #(
  parameter int DW = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef GMII_GTP_LOOPBACK_EN
  input  logic                  loopback,
`endif
  gmii_gtp_gearbox_if.slave     bus
);

  logic            tx_phase;
  logic [DW-1:0]   tx_lo;
  logic [DW-1:0]   rx_hi;
  logic            rx_pending;
  logic [2*DW-1:0] rx_word;
  logic            rx_stb;

`ifdef GMII_GTP_LOOPBACK_EN
  logic lb_q;

  // Register the loopback select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lb_q <= 1'b0;
    else        lb_q <= loopback;
  end

  // RX source: internal TX word or external GTP word
  always_comb begin
    rx_word = bus.gtp_rxd;
    rx_stb  = bus.gtp_rx_stb;
    if (lb_q) begin
      rx_word = bus.gtp_txd;
      rx_stb  = bus.gtp_tx_stb;
    end
  end
`else
  // RX source is always the external GTP word
  always_comb begin
    rx_word = bus.gtp_rxd;
    rx_stb  = bus.gtp_rx_stb;
  end
`endif

  // TX: hold the even symbol, emit the pair on the odd one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_phase       <= 1'b0;
      tx_lo          <= '0;
      bus.gtp_txd    <= '0;
      bus.gtp_tx_stb <= 1'b0;
    end else begin
      tx_phase <= ~tx_phase;
      if (!tx_phase) begin
        tx_lo          <= bus.gmii_txd;
        bus.gtp_tx_stb <= 1'b0;
      end else begin
        bus.gtp_txd    <= {bus.gmii_txd, tx_lo};
        bus.gtp_tx_stb <= 1'b1;
      end
    end
  end

  // RX: low half at once, high half next cycle; new word wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_hi              <= '0;
      rx_pending         <= 1'b0;
      bus.gmii_rxd       <= '0;
      bus.gmii_rx_valid  <= 1'b0;
      bus.rx_overrun     <= 1'b0;
      bus.rx_overrun_cnt <= '0;
    end else begin
      bus.rx_overrun <= 1'b0;
      if (rx_stb) begin
        bus.gmii_rxd      <= rx_word[DW-1:0];
        rx_hi             <= rx_word[2*DW-1:DW];
        rx_pending        <= 1'b1;
        bus.gmii_rx_valid <= 1'b1;
        if (rx_pending) begin
          bus.rx_overrun <= 1'b1;
          if (bus.rx_overrun_cnt != 8'hFF)
            bus.rx_overrun_cnt <= bus.rx_overrun_cnt + 8'd1;
        end
      end else if (rx_pending) begin
        bus.gmii_rxd      <= rx_hi;
        rx_pending        <= 1'b0;
        bus.gmii_rx_valid <= 1'b1;
      end else begin
        bus.gmii_rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gmii_gtp_gearbox.sv
// Directed bench for gmii_gtp_gearbox.
// Expected values are hand-computed constants.
module tb_gmii_gtp_gearbox;

  localparam int DW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DW-1:0]   txd_drv = '0;
  logic [2*DW-1:0] rxd_drv = '0;
  logic            rxs_drv = 1'b0;
  logic            ext_lb = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  gmii_gtp_gearbox_if #(.DW(DW)) bus ();

  assign bus.gmii_txd   = txd_drv;
  assign bus.gtp_rxd    = ext_lb ? bus.gtp_txd : rxd_drv;
  assign bus.gtp_rx_stb = ext_lb ? bus.gtp_tx_stb : rxs_drv;

  gmii_gtp_gearbox #(.DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef GMII_GTP_LOOPBACK_EN
    .loopback (1'b0),
`endif
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int bad;
    int ovr;

    // power-on reset
    #2;
    chk("por_txd", 32'(bus.gtp_txd), 0);
    chk("por_stb", 32'(bus.gtp_tx_stb), 0);
    chk("por_rxd", 32'(bus.gmii_rxd), 0);
    chk("por_vld", 32'(bus.gmii_rx_valid), 0);
    chk("por_cnt", 32'(bus.rx_overrun_cnt), 0);
    tick;
    tick;
    rst_n = 1'b1;

    // RX unpack, TX runs with nonzero data
    txd_drv = 10'h3FF;
    tick;
    rxd_drv = {10'h2A0, 10'h0FF};
    rxs_drv = 1'b1;
    tick;
    chk("rx_lo", 32'(bus.gmii_rxd), 32'h0FF);
    chk("rx_lo_vld", 32'(bus.gmii_rx_valid), 1);
    rxs_drv = 1'b0;
    tick;
    chk("rx_hi", 32'(bus.gmii_rxd), 32'h2A0);
    chk("rx_hi_vld", 32'(bus.gmii_rx_valid), 1);
    tick;
    chk("rx_idle_vld", 32'(bus.gmii_rx_valid), 0);
    chk("rx_idle_hold", 32'(bus.gmii_rxd), 32'h2A0);
    chk("pre_rst_txd", 32'(bus.gtp_txd), 32'hFFFFF);

    // mid-stream async reset, between edges
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_txd", 32'(bus.gtp_txd), 0);
    chk("rst_stb", 32'(bus.gtp_tx_stb), 0);
    chk("rst_rxd", 32'(bus.gmii_rxd), 0);
    chk("rst_vld", 32'(bus.gmii_rx_valid), 0);
    chk("rst_ovr", 32'(bus.rx_overrun), 0);
    chk("rst_cnt", 32'(bus.rx_overrun_cnt), 0);
    #2;
    rst_n = 1'b1;

    // TX packing after release
    txd_drv = 10'h155;
    tick;
    chk("tx_e1_stb", 32'(bus.gtp_tx_stb), 0);
    txd_drv = 10'h0D5;
    tick;
    chk("tx_e2_stb", 32'(bus.gtp_tx_stb), 1);
    chk("tx_w0", 32'(bus.gtp_txd), 32'h35555);
    txd_drv = 10'h001;
    tick;
    chk("tx_e3_stb", 32'(bus.gtp_tx_stb), 0);
    chk("tx_w0_hold", 32'(bus.gtp_txd), 32'h35555);
    txd_drv = 10'h002;
    tick;
    chk("tx_e4_stb", 32'(bus.gtp_tx_stb), 1);
    chk("tx_w1", 32'(bus.gtp_txd), 32'h00801);
    tick;
    chk("tx_e5_stb", 32'(bus.gtp_tx_stb), 0);

    // external loopback, counting pattern
    ext_lb = 1'b1;
    bad = 0;
    ovr = 0;
    for (int j = 0; j <= 200; j++) begin
      txd_drv = DW'(j);
      tick;
      if (bus.rx_overrun !== 1'b0) ovr++;
      if (j >= 4) begin
        if (bus.gmii_rxd !== DW'(j - 2)) bad++;
        if (bus.gmii_rx_valid !== 1'b1) bad++;
      end
    end
    chk("lb_data_errs", 32'(bad), 0);
    chk("lb_overruns", 32'(ovr), 0);
    chk("lb_cnt", 32'(bus.rx_overrun_cnt), 0);
    ext_lb = 1'b0;
    rxs_drv = 1'b0;
    tick;
    tick;
    tick;
    chk("drain_vld", 32'(bus.gmii_rx_valid), 0);

    // overrun: two back-to-back words
    rxd_drv = {10'h111, 10'h022};
    rxs_drv = 1'b1;
    tick;
    chk("ov_w1_lo", 32'(bus.gmii_rxd), 32'h022);
    chk("ov_none", 32'(bus.rx_overrun), 0);
    rxd_drv = {10'h333, 10'h044};
    tick;
    chk("ov_w2_lo", 32'(bus.gmii_rxd), 32'h044);
    chk("ov_pulse", 32'(bus.rx_overrun), 1);
    chk("ov_cnt1", 32'(bus.rx_overrun_cnt), 1);
    rxs_drv = 1'b0;
    tick;
    chk("ov_w2_hi", 32'(bus.gmii_rxd), 32'h333);
    chk("ov_pulse_end", 32'(bus.rx_overrun), 0);
    chk("ov_cnt1_hold", 32'(bus.rx_overrun_cnt), 1);
    tick;
    chk("ov_idle_vld", 32'(bus.gmii_rx_valid), 0);

    // saturation: 300 further overruns
    rxs_drv = 1'b1;
    tick;
    for (int k = 1; k <= 300; k++) begin
      tick;
      if (k == 253)
        chk("sat_254", 32'(bus.rx_overrun_cnt), 254);
      if (k == 254)
        chk("sat_255", 32'(bus.rx_overrun_cnt), 255);
    end
    chk("sat_end", 32'(bus.rx_overrun_cnt), 255);
    chk("sat_ovr", 32'(bus.rx_overrun), 1);
    rxs_drv = 1'b0;
    tick;
    tick;
    chk("sat_hold", 32'(bus.rx_overrun_cnt), 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gmii_gtp_gearbox.md
Name:
gmii_gtp_gearbox

Overview:
- Single-clock 1:2 / 2:1 width gearbox between the GMII-side symbol stream and the GTP transceiver parallel word.
- TX path: packs two consecutive DW-bit GMII symbols (8 data bits plus 2 control bits, as produced by the GMII link layer) into one 2*DW-bit GTP word, presented every second clock.
- RX path: unpacks each received 2*DW-bit word back into two DW-bit symbols, low half first.
- Sits between the GMII link/PCS block and the transceiver wrapper.

Parameters:
- DW, 10, symbol width in bits; GTP word width is 2*DW.

Ports:
- clk  input  1  symbol clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- gmii_txd  input  DW  TX symbol, one per clk.
- gtp_txd  output  2*DW  packed TX word; earlier symbol in [DW-1:0], later symbol in [2*DW-1:DW].
- gtp_tx_stb  output  1  one-cycle pulse; marks the cycle a new gtp_txd is first presented.
- gtp_rxd  input  2*DW  packed RX word; earlier symbol in the low half.
- gtp_rx_stb  input  1  qualifies gtp_rxd; sampled on clk edges.
- gmii_rxd  output  DW  unpacked RX symbol.
- gmii_rx_valid  output  1  high while gmii_rxd carries a fresh symbol.
- rx_overrun  output  1  one-cycle pulse when a word arrives before the previous high half was emitted.
- rx_overrun_cnt  output  8  saturating count of rx_overrun events.

Behaviour:
Reset (rst_n low, asynchronous):
- gtp_txd=0, gtp_tx_stb=0, gmii_rxd=0, gmii_rx_valid=0, rx_overrun=0, rx_overrun_cnt=0.
- tx_phase=0, rx_pending=0, internal holding registers=0.

TX path:
- tx_phase toggles every clk after reset release.
- tx_phase=0 edge: tx_lo <= gmii_txd; gtp_tx_stb <= 0; gtp_txd holds its value.
- tx_phase=1 edge: gtp_txd <= {gmii_txd, tx_lo}; gtp_tx_stb <= 1.
- Symbols A (cycle n, phase 0) and B (cycle n+1) produce gtp_txd={B,A} with gtp_tx_stb=1 during cycle n+2.
- gtp_txd is stable for two cycles per word.

RX path:
- Edge with gtp_rx_stb=1:
  - gmii_rxd <= gtp_rxd[DW-1:0]; rx_hi <= gtp_rxd[2*DW-1:DW].
  - rx_pending <= 1; gmii_rx_valid <= 1.
- Edge with gtp_rx_stb=0 and rx_pending=1: gmii_rxd <= rx_hi; rx_pending <= 0; gmii_rx_valid <= 1.
- Edge with gtp_rx_stb=0 and rx_pending=0: gmii_rxd holds; gmii_rx_valid <= 0.
- Simultaneous gtp_rx_stb=1 and rx_pending=1:
  - The new word wins and the pending high half is dropped.
  - rx_overrun <= 1 for one cycle.
  - rx_overrun_cnt increments and saturates at 255.
- Loopback (gtp_txd->gtp_rxd, gtp_tx_stb->gtp_rx_stb): symbol presented on gmii_txd in cycle n appears on gmii_rxd in cycle n+3, with gmii_rx_valid=1 continuously after fill.

Optional Feature:
- Macro: GMII_GTP_LOOPBACK_EN.
- Defined:
  - Adds input port loopback (1 bit).
  - When loopback=1, the RX path uses the internal gtp_txd/gtp_tx_stb in place of gtp_rxd/gtp_rx_stb.
  - gtp_txd still drives out normally.
  - The select is registered, so switching takes effect on the next clk edge.
- Undefined: port absent; RX path always uses gtp_rxd/gtp_rx_stb.

Test Plan:
- Reset: assert rst_n=0 mid-stream (async, between edges). Required: all outputs 0 immediately; after release, first gtp_tx_stb occurs on the 2nd edge.
- TX packing: drive gmii_txd 0x155, 0x0D5, 0x001, 0x002. Required: gtp_txd=0x35555 (hi 0x0D5, lo 0x155) then 0x00801, each with one-cycle gtp_tx_stb, stb period 2.
- RX unpacking: gtp_rxd=0x2A0FF with gtp_rx_stb=1 for one cycle. Required: gmii_rxd=0x0FF then 0x2A0 on the next two cycles, gmii_rx_valid=1 for both, then 0.
- Loopback via external wiring: counting pattern 0..200 on gmii_txd. Required: gmii_rxd equals gmii_txd delayed 3 cycles, no rx_overrun.
- Overrun: gtp_rx_stb high on two consecutive cycles with words W1, W2. Required: gmii_rxd=W1.lo then W2.lo, then W2.hi; rx_overrun pulses once; rx_overrun_cnt=1.
- Counter saturation: 300 overruns. Required: rx_overrun_cnt=255.
